adam_pause_drain: RTL and testbench
===================================

# adam_pause_drain

Pause endpoint placed directly downstream of `adam_pause_demux`: it terminates one `ADAM_PAUSE` master lane at a peripheral or bus port. On a pause request it blocks new transactions, waits for all outstanding transactions to complete, and only then stops the peripheral and acknowledges. On resume it re-enables the peripheral, waits a fixed settle delay, releases the transaction gate and acknowledges.

## Interface

Parameters:
- `MAX_OUTSTANDING`, default 4: maximum in-flight transactions tracked; must be ≥ 1.
- `RESUME_DELAY`, default 2: settle cycles between `run` rising and `hold` falling; 0 is legal.
- Counter width is `$clog2(MAX_OUTSTANDING+1)`.
- Resume counter width is `$clog2(RESUME_DELAY+1)`, minimum 1.

Ports:
- `seq.clk`, input, 1: clock. All logic is on the rising edge.
- `seq.rst`, input, 1: reset. Synchronous, active-high.
- `pause.req`, input, 1: pause request from the demux. 1 means pause, 0 means run. Level signalling.
- `pause.ack`, output, 1: equals `req` once the requested state is reached.
- `txn_start`, input, 1: one-cycle pulse; a transaction was accepted this cycle.
- `txn_done`, input, 1: one-cycle pulse; a transaction completed this cycle.
- `hold`, output, 1: when 1, the peripheral must not accept new transactions.
- `run`, output, 1: peripheral enable (clock-enable or function enable).
- `outstanding`, output, CW: current in-flight count.
- `err`, output, 1: sticky protocol error flag.

## Operation

- FSM states: `PAUSED`, `RESUMING`, `RUNNING`, `DRAINING`. All outputs are registered.
- Reset values: state `PAUSED`, `ack`=1, `hold`=1, `run`=0, `outstanding`=0, `err`=0. The block therefore comes out of reset paused, matching the demux's reset view.
- `PAUSED`: if `req`=0, go to `RESUMING`, set `run`=1, load the resume counter with `RESUME_DELAY`.
- `RESUMING`:
  - If the counter is 0, go to `RUNNING` with `hold`=0 and `ack`=0.
  - Otherwise decrement the counter.
- `RUNNING`:
  - If `req`=1, go to `DRAINING` with `hold`=1.
  - `hold` is also forced to 1 while `outstanding`==`MAX_OUTSTANDING` (backpressure), and released when the count drops.
- `DRAINING`: when the updated count is 0, go to `PAUSED` with `run`=0 and `ack`=1.
- Outstanding counter:
  - start only: +1.
  - done only: -1.
  - both in the same cycle: unchanged.
  - done at 0: count stays 0 and `err` is set.
  - start at `MAX_OUTSTANDING`: count saturates and `err` is set.
  - start while `hold` was 1: counted anyway and `err` is set.
- The counter keeps operating in every state, so completions arriving during `DRAINING` are counted.
- Four-phase rule: the master must not change `req` while `req`≠`ack`.
  - A `req` change during `RESUMING` or `DRAINING` is ignored until that transition completes.
  - After completion the block re-evaluates `req` in the next state.
  - Such a change is not an error.
- `err` is cleared only by reset.

## Timing

- Pause latency, with `req` sampled 1 at edge t in `RUNNING`:
  - `hold`=1 at t+1.
  - If the count is 0, `ack`=1 and `run`=0 at t+2.
  - Otherwise `ack` rises one cycle after the edge at which the count reaches 0.
- Resume latency, with `req` sampled 0 at edge t in `PAUSED`:
  - `run`=1 at t+1.
  - `hold`=0 and `ack`=0 at t+2+`RESUME_DELAY`.
- The cycle in which `hold` changes uses the registered `hold`: a `txn_start` on the same edge that `hold` rises is legal and is counted.
- Reset asserted mid-operation (any state, any count):
  - All outputs return to their reset values on the next edge.
  - The in-flight count is discarded.
  - `req` is ignored while reset is high.
- `req` is assumed synchronous to `seq.clk`; no synchronizer is included.

## Test plan

- **Reset then resume:** hold `seq.rst` 5 cycles with `req`=1, then `req`=0 and `RESUME_DELAY`=2.
  - During reset: `ack`=1, `hold`=1, `run`=0.
  - `run`=1 one cycle after `req` falls.
  - `ack`=0 and `hold`=0 exactly 4 cycles after `req` falls.
- **Idle pause:** in `RUNNING` with count 0, raise `req`.
  - `hold`=1 after 1 cycle.
  - `ack`=1 and `run`=0 after 2 cycles.
- **Drain:** issue 3 `txn_start`, raise `req`, deliver `txn_done` at +5, +10 and +20 cycles.
  - `ack` stays 0 until the third done.
  - `ack`=1 one cycle after `outstanding` reaches 0.
  - `run` stays 1 throughout draining.
- **Simultaneous start/done:** at count 2, pulse `txn_start` and `txn_done` in the same cycle.
  - Count stays 2, `err`=0.
- **Saturation and underflow:** with `MAX_OUTSTANDING`=4:
  - 4 starts give `hold`=1; a 5th start leaves count 4 and sets `err`=1.
  - After reset, a `txn_done` at count 0 sets `err`=1 and count stays 0.
- **Reset mid-drain:** assert reset in `DRAINING` with count 2.
  - On the next edge: `ack`=1, `hold`=1, `run`=0, `outstanding`=0, `err`=0.

Source files
------------

// File: rtl/adam_pause_drain.sv
// ============================================================================
// Module   : adam_pause_drain
// Brief    : Pause endpoint for one ADAM_PAUSE lane; gates new transactions,
//            drains in-flight ones, then stops the peripheral and acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adam_pause_drain #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned RESUME_DELAY    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pause_req,
    output logic                                   pause_ack,
    input  logic                                   txn_start,
    input  logic                                   txn_done,
    output logic                                   hold,
    output logic                                   run,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err
);

    localparam int unsigned c_CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned c_RW = (RESUME_DELAY == 0) ? 1 : $clog2(RESUME_DELAY + 1);
    localparam logic [c_CW-1:0] c_MAX    = c_CW'(MAX_OUTSTANDING);
    localparam logic [c_RW-1:0] c_RDELAY = c_RW'(RESUME_DELAY);

    typedef enum logic [1:0] {
        S_PAUSED   = 2'd0,
        S_RESUMING = 2'd1,
        S_RUNNING  = 2'd2,
        S_DRAINING = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ack;
    logic              r_hold;
    logic              r_run;
    logic              r_err;
    logic [c_CW-1:0]   r_cnt;
    logic [c_RW-1:0]   r_rcnt;

    logic [c_CW-1:0]   w_cnt_next;
    logic              w_err_evt;
    logic              w_full_next;

    // Saturating in-flight counter; protocol violations only raise the error.
    always_comb begin
        w_cnt_next = r_cnt;
        w_err_evt  = txn_start && r_hold;
        if (txn_start && !txn_done) begin
            if (r_cnt == c_MAX) begin
                w_err_evt = 1'b1;
            end else begin
                w_cnt_next = r_cnt + c_CW'(1);
            end
        end else if (!txn_start && txn_done) begin
            if (r_cnt == '0) begin
                w_err_evt = 1'b1;
            end else begin
                w_cnt_next = r_cnt - c_CW'(1);
            end
        end
    end

    assign w_full_next = (w_cnt_next == c_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PAUSED;
            r_ack   <= 1'b1;
            r_hold  <= 1'b1;
            r_run   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rcnt  <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_PAUSED: begin
                    if (!pause_req) begin
                        r_state <= S_RESUMING;
                        r_run   <= 1'b1;
                        r_rcnt  <= c_RDELAY;
                    end
                end
                S_RESUMING: begin
                    if (r_rcnt == '0) begin
                        r_state <= S_RUNNING;
                        r_hold  <= w_full_next;
                        r_ack   <= 1'b0;
                    end else begin
                        r_rcnt <= r_rcnt - c_RW'(1);
                    end
                end
                S_RUNNING: begin
                    if (pause_req) begin
                        r_state <= S_DRAINING;
                        r_hold  <= 1'b1;
                    end else begin
                        r_hold <= w_full_next;
                    end
                end
                S_DRAINING: begin
                    // Uses the updated count so a final completion stops the peripheral at once.
                    if (w_cnt_next == '0) begin
                        r_state <= S_PAUSED;
                        r_run   <= 1'b0;
                        r_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_PAUSED;
                end
            endcase
        end
    end

    assign pause_ack   = r_ack;
    assign hold        = r_hold;
    assign run         = r_run;
    assign outstanding = r_cnt;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_adam_pause_drain.sv
// ============================================================================
// Module   : tb_adam_pause_drain
// Brief    : Directed vector bench for adam_pause_drain (MAX_OUTSTANDING=4,
//            RESUME_DELAY=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adam_pause_drain;

    localparam int unsigned c_MAX = 4;
    localparam int unsigned c_RD  = 2;

    logic       clk;
    logic       rst;
    logic       pause_req;
    logic       pause_ack;
    logic       txn_start;
    logic       txn_done;
    logic       hold;
    logic       run;
    logic [2:0] outstanding;
    logic       err;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic       req;
        logic       start;
        logic       done;
        logic       ack;
        logic       hold;
        logic       run;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    adam_pause_drain #(
        .MAX_OUTSTANDING(c_MAX),
        .RESUME_DELAY   (c_RD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pause_req  (pause_req),
        .pause_ack  (pause_ack),
        .txn_start  (txn_start),
        .txn_done   (txn_done),
        .hold       (hold),
        .run        (run),
        .outstanding(outstanding),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic q, input logic s, input logic d,
                       input logic a, input logic h, input logic n, input logic [2:0] c,
                       input logic e);
        vec_t v;
        v.rst = r; v.req = q; v.start = s; v.done = d;
        v.ack = a; v.hold = h; v.run = n; v.cnt = c; v.err = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic a, input logic h, input logic n,
                         input logic [2:0] c, input logic e);
        checks++;
        if ({pause_ack, hold, run, outstanding, err} !== {a, h, n, c, e}) begin
            errors++;
            $display("FAIL %s: got ack=%b hold=%b run=%b cnt=%0d err=%b, expected ack=%b hold=%b run=%b cnt=%0d err=%b",
                     name, pause_ack, hold, run, outstanding, err, a, h, n, c, e);
        end
    endtask

    task automatic step(input logic r, input logic q, input logic s, input logic d);
        rst = r; pause_req = q; txn_start = s; txn_done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; pause_req = 1'b1; txn_start = 1'b0; txn_done = 1'b0;

        //   rst req st dn | ack hold run cnt err
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 1, 1, 0, 3'd0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 3'd0, 0);   // run rises one edge after req falls
        add(0, 0, 0, 0, 1, 1, 1, 3'd0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 3'd0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3'd0, 0);   // released 4 edges after req falls
        add(0, 1, 0, 0, 0, 1, 1, 3'd0, 0);   // idle pause: hold first
        add(0, 1, 0, 0, 1, 1, 0, 3'd0, 0);   // then ack / run off
        add(0, 0, 0, 0, 1, 1, 1, 3'd0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 3'd0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 3'd0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3'd0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 3'd1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 3'd2, 0);
        add(0, 0, 1, 1, 0, 0, 1, 3'd2, 0);   // simultaneous start/done
        add(0, 0, 1, 0, 0, 0, 1, 3'd3, 0);
        add(0, 0, 1, 0, 0, 1, 1, 3'd4, 0);   // full -> backpressure
        add(0, 0, 1, 0, 0, 1, 1, 3'd4, 1);   // 5th start saturates, err
        add(0, 0, 0, 1, 0, 0, 1, 3'd3, 1);   // hold released, err sticky
        add(1, 1, 0, 0, 1, 1, 0, 3'd0, 0);
        add(0, 1, 0, 1, 1, 1, 0, 3'd0, 1);   // underflow at 0
        add(1, 1, 0, 0, 1, 1, 0, 3'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].start, vecs[i].done);
            check($sformatf("vec%0d", i), vecs[i].ack, vecs[i].hold, vecs[i].run,
                  vecs[i].cnt, vecs[i].err);
        end

        // Drain: three in flight, completions at +5, +10, +20 after pause request.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("drain_resumed", 0, 0, 1, 3'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("drain_loaded", 0, 0, 1, 3'd3, 0);
        step(0, 1, 0, 0);
        check("drain_hold", 0, 1, 1, 3'd3, 0);
        begin
            logic [2:0] exp_cnt;
            exp_cnt = 3'd3;
            for (int k = 1; k <= 20; k++) begin
                logic d;
                d = (k == 5) || (k == 10) || (k == 20);
                if (d) exp_cnt = exp_cnt - 3'd1;
                step(0, 1, 0, d);
                if (k < 20) check($sformatf("drain_k%0d", k), 0, 1, 1, exp_cnt, 0);
                else        check("drain_done", 1, 1, 0, 3'd0, 0);
            end
        end

        // Reset while draining with two in flight.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check("pre_reset_drain", 0, 1, 1, 3'd2, 0);
        step(0, 1, 0, 0);
        check("still_draining", 0, 1, 1, 3'd2, 0);
        step(1, 0, 0, 0);
        check("reset_mid_drain", 1, 1, 0, 3'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
